// File: rtl/iddr_word_rx.sv
// DDR receive word assembler: hunts for SYNC in the rise/fall pair stream and packs WORD_W-bit words MSB first.
// Optional SYNC-per-frame supervision is compiled in with `define IDDR_RX_FRAME_CHECK_EN.
module iddr_word_rx #(
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] SYNC      = 8'hD5,
    parameter int                FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              d_rise,
    input  logic              d_fall,
    output logic              locked,
    output logic              phase,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              sync_seen,
    output logic              frame_err
);
    localparam int PAIRS  = WORD_W / 2;
    localparam int CNT_W  = $clog2(PAIRS);
    localparam int WCNT_W = $clog2(FRAME_LEN + 1);

    if (WORD_W < 4 || (WORD_W % 2) != 0 || FRAME_LEN < 1) begin : g_bad_params
        $error("iddr_word_rx: WORD_W must be even and >= 4, FRAME_LEN >= 1");
    end

    typedef enum logic {HUNT, LOCK} state_t;

    state_t             state_q, state_d;
    logic [WORD_W:0]    sr_q, sr_d, sr_shift;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               word_valid_q, word_valid_d;
    logic [WORD_W-1:0]  word_data_q, word_data_d;
    logic [WORD_W-1:0]  word_sel;
    logic               sync_seen_q, sync_seen_d;
    logic               frame_err_q, frame_err_d;
`ifdef IDDR_RX_FRAME_CHECK_EN
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
`endif

    always_comb begin
        sr_shift     = {sr_q[WORD_W-2:0], d_rise, d_fall};
        state_d      = state_q;
        sr_d         = sr_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        sync_seen_d  = 1'b0;
        frame_err_d  = 1'b0;
        // Phase 1 boundary sits one bit back, so the newest d_fall starts the next word.
        word_sel     = phase_q ? sr_shift[WORD_W:1] : sr_shift[WORD_W-1:0];
`ifdef IDDR_RX_FRAME_CHECK_EN
        wcnt_d       = wcnt_q;
`endif
        if (!en) begin
            state_d = HUNT;
            sr_d    = '0;
            cnt_d   = '0;
`ifdef IDDR_RX_FRAME_CHECK_EN
            wcnt_d  = '0;
`endif
        end else begin
            sr_d = sr_shift;
            case (state_q)
                HUNT: begin
                    if (sr_shift[WORD_W-1:0] == SYNC || sr_shift[WORD_W:1] == SYNC) begin
                        state_d     = LOCK;
                        phase_d     = (sr_shift[WORD_W-1:0] != SYNC);
                        cnt_d       = '0;
                        sync_seen_d = 1'b1;
`ifdef IDDR_RX_FRAME_CHECK_EN
                        wcnt_d      = '0;
`endif
                    end
                end
                LOCK: begin
                    if (cnt_q == CNT_W'(PAIRS - 1)) begin
                        cnt_d = '0;
`ifdef IDDR_RX_FRAME_CHECK_EN
                        if (wcnt_q == WCNT_W'(FRAME_LEN)) begin
                            if (word_sel == SYNC) begin
                                sync_seen_d = 1'b1;
                                wcnt_d      = '0;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = HUNT;
                            end
                        end else begin
                            word_valid_d = 1'b1;
                            word_data_d  = word_sel;
                            wcnt_d       = wcnt_q + 1'b1;
                        end
`else
                        word_valid_d = 1'b1;
                        word_data_d  = word_sel;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            phase_q      <= 1'b0;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            sync_seen_q  <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef IDDR_RX_FRAME_CHECK_EN
            wcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            sync_seen_q  <= sync_seen_d;
            frame_err_q  <= frame_err_d;
`ifdef IDDR_RX_FRAME_CHECK_EN
            wcnt_q       <= wcnt_d;
`endif
        end
    end

    assign locked     = (state_q == LOCK);
    assign phase      = phase_q;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign sync_seen  = sync_seen_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_iddr_word_rx.sv
// Bench for iddr_word_rx: bit-stream reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_iddr_word_rx;
    localparam int         WORD_W    = 8;
    localparam logic [7:0] SYNC      = 8'hD5;
    localparam int         FRAME_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       d_rise = 1'b0;
    logic       d_fall = 1'b0;
    logic       locked, phase, word_valid, sync_seen, frame_err;
    logic [7:0] word_data;

    iddr_word_rx #(.WORD_W(WORD_W), .SYNC(SYNC), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst(rst), .en(en), .d_rise(d_rise), .d_fall(d_fall),
        .locked(locked), .phase(phase), .word_valid(word_valid),
        .word_data(word_data), .sync_seen(sync_seen), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wv_count = 0;
    int ss_count = 0;
    int fe_count = 0;

    // Reference model: history of received bits (zero-padded after a clear),
    // SYNC position, and words cut every WORD_W bits after it.
    bit         hist[$];
    int         sync_end;
    bit         m_locked, m_phase;
    int         m_wcnt;
    bit         exp_wv, exp_ss, exp_fe;
    logic [7:0] exp_wd;

    function automatic logic [7:0] window(int start);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[7-i] = hist[start+i];
        return w;
    endfunction

    task automatic model_clear();
        hist.delete();
        repeat (9) hist.push_back(1'b0);
        m_locked = 1'b0;
        m_wcnt   = 0;
        sync_end = 0;
    endtask

    task automatic model_step();
        int n;
        logic [7:0] w;
        exp_wv = 1'b0;
        exp_ss = 1'b0;
        exp_fe = 1'b0;
        if (!en) begin
            model_clear();
        end else begin
            hist.push_back(d_rise);
            hist.push_back(d_fall);
            n = hist.size();
            if (!m_locked) begin
                if (window(n - 8) == SYNC) begin
                    m_locked = 1'b1; m_phase = 1'b0; sync_end = n;
                end else if (window(n - 9) == SYNC) begin
                    m_locked = 1'b1; m_phase = 1'b1; sync_end = n - 1;
                end
                if (m_locked) begin
                    exp_ss = 1'b1;
                    m_wcnt = 0;
                end
            end else if (n - sync_end >= WORD_W) begin
                w = window(sync_end);
                sync_end += WORD_W;
`ifdef IDDR_RX_FRAME_CHECK_EN
                if (m_wcnt == FRAME_LEN) begin
                    if (w == SYNC) begin
                        exp_ss = 1'b1; m_wcnt = 0;
                    end else begin
                        exp_fe = 1'b1; m_locked = 1'b0;
                    end
                end else begin
                    exp_wv = 1'b1; exp_wd = w; m_wcnt++;
                end
`else
                exp_wv = 1'b1;
                exp_wd = w;
`endif
            end
        end
    endtask

    initial begin
        model_clear();
        m_phase = 1'b0; exp_wd = 8'h00; exp_wv = 1'b0; exp_ss = 1'b0; exp_fe = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
                m_phase = 1'b0; exp_wd = 8'h00; exp_wv = 1'b0; exp_ss = 1'b0; exp_fe = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("locked", {31'b0, locked}, {31'b0, m_locked});
        check("word_valid", {31'b0, word_valid}, {31'b0, exp_wv});
        check("sync_seen", {31'b0, sync_seen}, {31'b0, exp_ss});
        check("frame_err", {31'b0, frame_err}, {31'b0, exp_fe});
        check("word_data", {24'b0, word_data}, {24'b0, exp_wd});
        if (m_locked) check("phase", {31'b0, phase}, {31'b0, m_phase});
        if (word_valid === 1'b1) begin
            wv_count++;
            $display("word %02h at %0t", word_data, $time);
        end
        if (sync_seen === 1'b1) ss_count++;
        if (frame_err === 1'b1) fe_count++;
    endtask

    // Outputs only move on posedge/rst, so the negedge is a safe point to compare and drive.
    task automatic drive(input bit e, input bit r, input bit f);
        @(negedge clk);
        compare_all();
        en = e; d_rise = r; d_fall = f;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i > 0; i -= 2) drive(1'b1, b[i], b[i-1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int wv0, ss0, fe0;
        logic [7:0] stream_a [7];
        logic [7:0] stream_b [7];
        stream_a = '{8'hD5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hD5, 8'h55};
        stream_b = '{8'hD5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h55};

        // 1: reset, then idle zeros never lock
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idle(10);
        check("idle_locked", {31'b0, locked}, 32'd0);
        check("idle_data", {24'b0, word_data}, 32'd0);

        // 2: phase 0 lock then 8'h3C
        send_byte(SYNC);
        drive(1'b1, 1'b0, 1'b0);
        check("p0_sync_seen", {31'b0, sync_seen}, 32'd1);
        check("p0_locked", {31'b0, locked}, 32'd1);
        check("p0_phase", {31'b0, phase}, 32'd0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("p0_word_valid", {31'b0, word_valid}, 32'd1);
        check("p0_word_data", {24'b0, word_data}, 32'h3C);

        // 3: phase 1 - bits 0, D5, A5, pad 0
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        check("p1_sync_seen", {31'b0, sync_seen}, 32'd1);
        check("p1_phase", {31'b0, phase}, 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("p1_word_valid", {31'b0, word_valid}, 32'd1);
        check("p1_word_data", {24'b0, word_data}, 32'hA5);

        // 4: en dropped mid-word, then 3C alone must not lock
        drive(1'b0, 1'b0, 1'b0);
        send_byte(SYNC);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        wv0 = wv_count;
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        check("en_low_locked", {31'b0, locked}, 32'd0);
        send_byte(8'h3C);
        idle(6);
        check("en_low_no_word", wv_count, wv0);
        check("nolock_3c", {31'b0, locked}, 32'd0);

        // 5a: framed stream with second SYNC
        drive(1'b0, 1'b0, 1'b0);
        wv0 = wv_count; ss0 = ss_count; fe0 = fe_count;
        foreach (stream_a[i]) send_byte(stream_a[i]);
        idle(2);
        check("fa_last_data", {24'b0, word_data}, 32'h55);
`ifdef IDDR_RX_FRAME_CHECK_EN
        check("fa_wv_count", wv_count - wv0, 32'd5);
        check("fa_ss_count", ss_count - ss0, 32'd2);
`else
        check("fa_wv_count", wv_count - wv0, 32'd6);
        check("fa_ss_count", ss_count - ss0, 32'd1);
`endif
        check("fa_fe_count", fe_count - fe0, 32'd0);

        // 5b: second SYNC replaced by 00
        drive(1'b0, 1'b0, 1'b0);
        wv0 = wv_count; fe0 = fe_count;
        foreach (stream_b[i]) send_byte(stream_b[i]);
        idle(2);
`ifdef IDDR_RX_FRAME_CHECK_EN
        check("fb_wv_count", wv_count - wv0, 32'd4);
        check("fb_fe_count", fe_count - fe0, 32'd1);
        check("fb_locked", {31'b0, locked}, 32'd0);
`else
        check("fb_wv_count", wv_count - wv0, 32'd6);
        check("fb_fe_count", fe_count - fe0, 32'd0);
        check("fb_locked", {31'b0, locked}, 32'd1);
`endif

        // 6: async reset between edges in the middle of a word
        drive(1'b0, 1'b0, 1'b0);
        send_byte(SYNC);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_locked", {31'b0, locked}, 32'd0);
        check("rst_word_valid", {31'b0, word_valid}, 32'd0);
        check("rst_word_data", {24'b0, word_data}, 32'd0);
        check("rst_phase", {31'b0, phase}, 32'd0);
        wv0 = wv_count;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        idle(8);
        check("rst_no_word", wv_count, wv0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
